// File: rtl/clint_irq_gen.sv
// CLINT-style machine interrupt source: mtime/mtimecmp timer, MSIP bit,
// and a two-flop synchronizer for the external interrupt pin.
module clint_irq_gen #(
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 5
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              wr_en_in,
    input  logic              rd_en_in,
    input  logic [31:0]       wdata_in,
    output logic [31:0]       rdata_out,
    input  logic              ext_irq_in,
    output logic              e_irq_out,
    output logic              t_irq_out,
    output logic              s_irq_out
);

    localparam int WW = ADDR_W - 2;
    localparam logic [WW-1:0] A_MSIP    = WW'(0);
    localparam logic [WW-1:0] A_CMP_LO  = WW'(1);
    localparam logic [WW-1:0] A_CMP_HI  = WW'(2);
    localparam logic [WW-1:0] A_TIME_LO = WW'(3);
    localparam logic [WW-1:0] A_TIME_HI = WW'(4);
    localparam logic [15:0]   PS_LAST   = 16'(PRESCALE - 1);

    logic [WW-1:0] word;
    logic          addr_unused;
    logic [15:0]   psc;
    logic          tick;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic [1:0]    sync_q;
    logic [31:0]   rd_mux;
    logic          wr_tlo;
    logic          wr_thi;

    assign word        = addr_in[ADDR_W-1:2];
    assign addr_unused = ^addr_in[1:0];
    assign tick        = (psc == PS_LAST);
    assign wr_tlo      = wr_en_in && (word == A_TIME_LO);
    assign wr_thi      = wr_en_in && (word == A_TIME_HI);

    // A TIME write restarts the prescale period and suppresses that cycle's tick.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            psc   <= '0;
            mtime <= '0;
        end else begin
            if (wr_tlo || wr_thi || tick) begin
                psc <= '0;
            end else begin
                psc <= psc + 16'd1;
            end
            if (wr_tlo) begin
                mtime[31:0] <= wdata_in;
            end else if (wr_thi) begin
                mtime[63:32] <= wdata_in;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else if (wr_en_in) begin
            if (word == A_CMP_LO) begin
                mtimecmp[31:0] <= wdata_in;
            end
            if (word == A_CMP_HI) begin
                mtimecmp[63:32] <= wdata_in;
            end
            if (word == A_MSIP) begin
                msip <= wdata_in[0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word)
            A_MSIP:    rd_mux = {31'd0, msip};
            A_CMP_LO:  rd_mux = mtimecmp[31:0];
            A_CMP_HI:  rd_mux = mtimecmp[63:32];
            A_TIME_LO: rd_mux = mtime[31:0];
            A_TIME_HI: rd_mux = mtime[63:32];
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rdata_out <= '0;
            t_irq_out <= 1'b0;
            sync_q    <= '0;
        end else begin
            if (rd_en_in) begin
                rdata_out <= rd_mux;
            end
            t_irq_out <= (mtime >= mtimecmp);
            sync_q    <= {sync_q[0], ext_irq_in};
        end
    end

    assign e_irq_out = sync_q[1];
    assign s_irq_out = msip;

endmodule

// File: tb/tb_clint_irq_gen.sv
// Directed bench for clint_irq_gen: two instances (PRESCALE 4 and 1)
// share one bus; read results flow through an expected-value queue.
module tb_clint_irq_gen;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          sel;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  addr = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wdata = '0;
    logic        ext = 1'b0;
    logic [31:0] rdata4, rdata1;
    logic        e4, t4, s4, e1, t1, s1;

    int vectors = 0;
    int errors  = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    clint_irq_gen #(.PRESCALE(4), .ADDR_W(5)) u4 (
        .clk_in(clk), .rst_n_in(rst_n), .addr_in(addr),
        .wr_en_in(wr_en), .rd_en_in(rd_en), .wdata_in(wdata),
        .rdata_out(rdata4), .ext_irq_in(ext),
        .e_irq_out(e4), .t_irq_out(t4), .s_irq_out(s4)
    );

    clint_irq_gen #(.PRESCALE(1), .ADDR_W(5)) u1 (
        .clk_in(clk), .rst_n_in(rst_n), .addr_in(addr),
        .wr_en_in(wr_en), .rd_en_in(rd_en), .wdata_in(wdata),
        .rdata_out(rdata1), .ext_irq_in(ext),
        .e_irq_out(e1), .t_irq_out(t1), .s_irq_out(s1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                      input bit sel, input string tag);
        sb_t e;
        addr  = a;
        rd_en = 1'b1;
        e.tag = tag;
        e.exp = exp;
        e.sel = sel;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        e = sb.pop_front();
        chk(e.tag, e.sel ? rdata4 : rdata1, e.exp);
    endtask

    task automatic wrrd(input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
        sb_t e;
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        rd_en = 1'b1;
        e.tag = tag;
        e.exp = exp;
        e.sel = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        e = sb.pop_front();
        chk(e.tag, rdata4, e.exp);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_e", {31'd0, e4}, 32'd0);
        chk("rst_t", {31'd0, t4}, 32'd0);
        chk("rst_s", {31'd0, s4}, 32'd0);
        chk("rst_rdata", rdata4, 32'd0);
        rst_n = 1'b1;
        rd(5'h04, 32'hFFFF_FFFF, 1'b1, "rst_cmp_lo");
        rd(5'h08, 32'hFFFF_FFFF, 1'b1, "rst_cmp_hi");

        // software interrupt
        wr(5'h00, 32'hFFFF_FFFF);
        chk("msip_set", {31'd0, s4}, 32'd1);
        rd(5'h00, 32'd1, 1'b1, "msip_rd1");
        wr(5'h00, 32'hFFFF_FFFE);
        chk("msip_clr", {31'd0, s4}, 32'd0);
        rd(5'h00, 32'd0, 1'b1, "msip_rd0");
        wrrd(5'h00, 32'd1, 32'd0, "rw_old");
        chk("msip_rw", {31'd0, s4}, 32'd1);
        wr(5'h00, 32'd0);

        // timer compare with PRESCALE=4
        wr(5'h08, 32'd0);
        wr(5'h10, 32'd0);
        wr(5'h0C, 32'd0);
        wr(5'h04, 32'd10);
        repeat (39) @(posedge clk);
        #1;
        chk("t_before", {31'd0, t4}, 32'd0);
        @(posedge clk);
        #1;
        chk("t_rise", {31'd0, t4}, 32'd1);
        wr(5'h04, 32'd100);
        chk("t_hold", {31'd0, t4}, 32'd1);
        @(posedge clk);
        #1;
        chk("t_fall", {31'd0, t4}, 32'd0);

        // carry across halves, write beats tick (PRESCALE=1)
        wr(5'h0C, 32'hFFFF_FFFF);
        wr(5'h10, 32'd0);
        rd(5'h10, 32'd0, 1'b0, "carry_pre");
        rd(5'h10, 32'd1, 1'b0, "carry_hi");
        rd(5'h0C, 32'd1, 1'b0, "carry_lo");
        wr(5'h0C, 32'h1234_0000);
        rd(5'h0C, 32'h1234_0000, 1'b0, "wr_wins");

        // TIME write restarts the prescaler
        wr(5'h0C, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            rd(5'h0C, (k == 5) ? 32'd1 : 32'd0, 1'b1, "psc_step");
        end

        // 64-bit wrap
        wr(5'h0C, 32'hFFFF_FFFF);
        wr(5'h10, 32'hFFFF_FFFF);
        rd(5'h10, 32'hFFFF_FFFF, 1'b0, "wrap_pre");
        rd(5'h0C, 32'd0, 1'b0, "wrap_lo");

        // external interrupt synchronizer
        wr(5'h00, 32'd1);
        wr(5'h10, 32'd1);
        @(posedge clk);
        #3;
        ext = 1'b1;
        @(posedge clk);
        #1;
        chk("ext_lat1", {31'd0, e4}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("ext_high", {31'd0, e4}, 32'd1);
            if (i == 3) begin
                #2;
                ext = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("ext_low", {31'd0, e4}, 32'd0);

        // reset mid-pulse
        ext = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_e", {31'd0, e4}, 32'd1);
        chk("pre_rst_t", {31'd0, t4}, 32'd1);
        chk("pre_rst_s", {31'd0, s4}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_e", {31'd0, e4}, 32'd0);
        chk("arst_t", {31'd0, t4}, 32'd0);
        chk("arst_s", {31'd0, s4}, 32'd0);
        chk("arst_rdata", rdata4, 32'd0);
        ext = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // unmapped offsets
        wr(5'h00, 32'd1);
        wr(5'h04, 32'hA5A5_0001);
        wr(5'h08, 32'h0000_00B2);
        wr(5'h0C, 32'h0000_5000);
        wr(5'h14, 32'hDEAD_BEEF);
        rd(5'h14, 32'd0, 1'b1, "rd_14");
        rd(5'h1C, 32'd0, 1'b1, "rd_1c");
        rd(5'h00, 32'd1, 1'b1, "keep_msip");
        rd(5'h04, 32'hA5A5_0001, 1'b1, "keep_cmp_lo");
        rd(5'h08, 32'h0000_00B2, 1'b1, "keep_cmp_hi");
        rd(5'h10, 32'd0, 1'b1, "keep_time_hi");
        rd(5'h0C, 32'h0000_5001, 1'b1, "keep_time_lo");
        @(posedge clk);
        #1;
        chk("rdata_hold", rdata4, 32'h0000_5001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
